// File: rtl/ram1_uart_ctrl_pkg.sv
// Shared constants and encodings for the RAM1/UART memory-stage controller.
package mem_pkg;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_RAM_WR1,
    ST_RAM_WR2,
    ST_U_RD1,
    ST_U_RD2,
    ST_U_WR1,
    ST_U_WR2,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_RAM_RD,
    OP_RAM_WR,
    OP_U_RD,
    OP_U_WR,
    OP_U_STAT,
    OP_NOP
  } op_t;

  // First state entered once a request of the given kind is accepted.
  function automatic state_t entry_state(op_t op);
    case (op)
      OP_RAM_RD: entry_state = ST_RAM_RD;
      OP_RAM_WR: entry_state = ST_RAM_WR1;
      OP_U_RD:   entry_state = ST_U_RD1;
      OP_U_WR:   entry_state = ST_U_WR1;
      default:   entry_state = ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/ram1_uart_ctrl_if.sv
// Pipeline-side request/response bundle of the RAM1/UART controller.
interface ram1_uart_ctrl_if;
  logic        is_RAM1_i;
  logic        is_UART_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output is_RAM1_i, is_UART_i, memread_i, memwrite_i, addr_i, wdata_i,
    input  rdata_o, busy_o, done_o
  );

  modport slave (
    input  is_RAM1_i, is_UART_i, memread_i, memwrite_i, addr_i, wdata_i,
    output rdata_o, busy_o, done_o
  );
endinterface

// File: rtl/ram1_uart_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous UART status pins.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_p0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end
endmodule

// File: rtl/ram1_uart_ctrl.sv
// RAM1 SRAM / UART access sequencer sharing one 16-bit data bus.
// Optional macro UART_TX_WAIT_EN: UART writes wait for the transmitter to be idle.
module ram1_uart_ctrl #(
  parameter int          ADDR_W         = 18,
  parameter logic [15:0] UART_DATA_ADDR = mem_pkg::UART_DATA_ADDR,
  parameter logic [15:0] UART_STAT_ADDR = mem_pkg::UART_STAT_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  ram1_uart_ctrl_if.slave   mem,
  output logic [ADDR_W-1:0] ram1_addr_o,
  inout  wire  [15:0]       ram1_data_io,
  output logic              ram1_en_o,
  output logic              ram1_oe_o,
  output logic              ram1_we_o,
  output logic              rdn_o,
  output logic              wrn_o,
  input  logic              data_ready_i,
  input  logic              tbre_i,
  input  logic              tsre_i
);
  import mem_pkg::*;

  state_t      state, next;
  op_t         op;
  logic        req, accept, tx_ready, bus_drive;
  logic        data_ready_s, tbre_s, tsre_s;
  logic [15:0] wdata_q, rdata_q, status;

  sync2 u_sync_dr   (.clk(clk), .rst(rst), .d(data_ready_i), .q(data_ready_s));
  sync2 u_sync_tbre (.clk(clk), .rst(rst), .d(tbre_i),       .q(tbre_s));
  sync2 u_sync_tsre (.clk(clk), .rst(rst), .d(tsre_i),       .q(tsre_s));

  assign tx_ready = tbre_s & tsre_s;
  assign status   = {14'b0, data_ready_s, tx_ready};
  assign req      = (mem.is_RAM1_i | mem.is_UART_i) & (mem.memread_i | mem.memwrite_i);

  // UART select outranks RAM1; a load outranks a store.
  always_comb begin
    op = OP_NOP;
    if (mem.is_UART_i) begin
      if (mem.addr_i == UART_DATA_ADDR)
        op = mem.memread_i ? OP_U_RD : OP_U_WR;
      else if (mem.addr_i == UART_STAT_ADDR && mem.memread_i)
        op = OP_U_STAT;
    end else if (mem.is_RAM1_i) begin
      op = mem.memread_i ? OP_RAM_RD : OP_RAM_WR;
    end
  end

`ifdef UART_TX_WAIT_EN
  assign accept = req & ~((op == OP_U_WR) & ~tx_ready);
`else
  assign accept = req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ram1_addr_o <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state <= next;
      if (state == ST_IDLE && accept) begin
        ram1_addr_o <= {{(ADDR_W-16){1'b0}}, mem.addr_i};
        wdata_q     <= mem.wdata_i;
        if (op == OP_U_STAT)
          rdata_q <= status;
      end
      if (state == ST_RAM_RD || state == ST_U_RD1)
        rdata_q <= ram1_data_io;
    end
  end

  always_comb begin
    next      = state;
    ram1_en_o = 1'b1;
    ram1_oe_o = 1'b1;
    ram1_we_o = 1'b1;
    rdn_o     = 1'b1;
    wrn_o     = 1'b1;
    bus_drive = 1'b0;
    case (state)
      ST_IDLE:    if (accept) next = entry_state(op);
      ST_RAM_RD: begin
        ram1_en_o = 1'b0;
        ram1_oe_o = 1'b0;
        next      = ST_DONE;
      end
      ST_RAM_WR1: begin
        ram1_en_o = 1'b0;
        ram1_we_o = 1'b0;
        bus_drive = 1'b1;
        next      = ST_RAM_WR2;
      end
      ST_RAM_WR2: begin
        ram1_en_o = 1'b0;
        bus_drive = 1'b1;
        next      = ST_DONE;
      end
      ST_U_RD1: begin
        rdn_o = 1'b0;
        next  = ST_U_RD2;
      end
      ST_U_RD2:   next = ST_DONE;
      ST_U_WR1: begin
        wrn_o     = 1'b0;
        bus_drive = 1'b1;
        next      = ST_U_WR2;
      end
      ST_U_WR2: begin
        bus_drive = 1'b1;
`ifdef UART_TX_WAIT_EN
        if (tx_ready) next = ST_DONE;
`else
        next = ST_DONE;
`endif
      end
      ST_DONE:    next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  assign ram1_data_io = bus_drive ? wdata_q : 16'hzzzz;
  assign mem.rdata_o  = rdata_q;
  assign mem.done_o   = (state == ST_DONE);
  assign mem.busy_o   = ((state == ST_IDLE) & req) |
                        ((state != ST_IDLE) & (state != ST_DONE));
endmodule
